// File: rtl/tensor_core_host_sequencer_if.sv
// Byte-serial host link for the tensor core host sequencer.
// Host is master; the sequencer is slave on both directions.
interface tensor_core_host_sequencer_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] host_in_data;
  logic              host_in_valid;
  logic              host_in_ready;
  logic [DATA_W-1:0] host_out_data;
  logic              host_out_valid;
  logic              host_out_ready;

  modport master (
    output host_in_data,
    output host_in_valid,
    input  host_in_ready,
    input  host_out_data,
    input  host_out_valid,
    output host_out_ready
  );

  modport slave (
    input  host_in_data,
    input  host_in_valid,
    output host_in_ready,
    output host_out_data,
    output host_out_valid,
    input  host_out_ready
  );
endinterface

// File: rtl/tensor_core_host_sequencer.sv
// Host-side command/operand loader and result drainer for the 3x3 tensor core.
// Optional TENSOR_HOST_SEQ_CHECKSUM_EN: XOR checksum byte, reject bad commands.
module tensor_core_host_sequencer #(
  parameter int COMPUTE_CYCLES = 10,
  parameter int DATA_W         = 8
) (
  input  logic tensor_core_clock,
  input  logic reset_in,

  tensor_core_host_sequencer_if.slave host,

  output logic signed [DATA_W-1:0] tensor_core_input1 [0:2][0:2],
  output logic signed [DATA_W-1:0] tensor_core_input2 [0:2][0:2],
  output logic tensor_core_register_file_write_enable,
  output logic should_start_tensor_core,
  output logic [1:0] operation_select,
  input  logic signed [DATA_W-1:0] tensor_core_output [0:2][0:2],
  output logic busy
);

  localparam int WAIT_W =
    (COMPUTE_CYCLES > 2) ? $clog2(COMPUTE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    START,
    WAIT,
    CAPTURE,
    DRAIN
  } state_t;

  state_t state;

  logic [1:0] row;
  logic [1:0] col;
  logic [1:0] nxt_row;
  logic [1:0] nxt_col;
  logic       second;
  logic       last_elem;
  logic       hs_in;
  logic       hs_out;
  logic       cmd_ok;
  logic       drain_done;

  logic [WAIT_W-1:0] wait_cnt;

  logic signed [DATA_W-1:0] result_q [0:2][0:2];

  assign hs_in  = host.host_in_valid && host.host_in_ready;
  assign hs_out = host.host_out_valid && host.host_out_ready;

  // row/col walk a 3x3 matrix row-major; second selects operand B
  assign last_elem = (row == 2'd2) && (col == 2'd2);

  always_comb begin
    nxt_row = row;
    nxt_col = col + 2'd1;
    if (col == 2'd2) begin
      nxt_col = 2'd0;
      nxt_row = (row == 2'd2) ? 2'd0 : row + 2'd1;
    end
  end

`ifdef TENSOR_HOST_SEQ_CHECKSUM_EN
  logic              chk_phase;
  logic [DATA_W-1:0] csum;

  assign cmd_ok     = ~|host.host_in_data[DATA_W-1:2];
  assign drain_done = hs_out && chk_phase;

  always_comb begin
    csum = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        csum = csum ^ result_q[i][j];
      end
    end
  end
`else
  logic unused_cmd_bits;

  assign unused_cmd_bits = ^host.host_in_data[DATA_W-1:2];
  assign cmd_ok          = 1'b1;
  assign drain_done      = hs_out && last_elem;
`endif

  always_ff @(posedge tensor_core_clock or posedge reset_in) begin
    if (reset_in) begin
      state    <= IDLE;
      row      <= 2'd0;
      col      <= 2'd0;
      second   <= 1'b0;
      wait_cnt <= '0;
      result_q <= '{default: '0};
      tensor_core_input1 <= '{default: '0};
      tensor_core_input2 <= '{default: '0};
      tensor_core_register_file_write_enable <= 1'b0;
      should_start_tensor_core <= 1'b0;
      operation_select    <= 2'b00;
      busy                <= 1'b0;
      host.host_in_ready  <= 1'b1;
      host.host_out_valid <= 1'b0;
      host.host_out_data  <= '0;
`ifdef TENSOR_HOST_SEQ_CHECKSUM_EN
      chk_phase <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (hs_in && cmd_ok) begin
            operation_select <= host.host_in_data[1:0];
            row    <= 2'd0;
            col    <= 2'd0;
            second <= 1'b0;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (hs_in) begin
            if (second) begin
              tensor_core_input2[row][col] <= host.host_in_data;
            end else begin
              tensor_core_input1[row][col] <= host.host_in_data;
            end
            row <= nxt_row;
            col <= nxt_col;
            if (last_elem) begin
              second <= 1'b1;
            end
            if (last_elem && second) begin
              host.host_in_ready <= 1'b0;
              tensor_core_register_file_write_enable <= 1'b1;
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          tensor_core_register_file_write_enable <= 1'b0;
          should_start_tensor_core <= 1'b1;
          state <= START;
        end
        START: begin
          should_start_tensor_core <= 1'b0;
          wait_cnt <= WAIT_W'(COMPUTE_CYCLES - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state <= CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        CAPTURE: begin
          // buffer fills this edge, so byte 0 is taken straight from the core
          result_q <= tensor_core_output;
          row <= 2'd0;
          col <= 2'd0;
          host.host_out_data  <= tensor_core_output[0][0];
          host.host_out_valid <= 1'b1;
`ifdef TENSOR_HOST_SEQ_CHECKSUM_EN
          chk_phase <= 1'b0;
`endif
          state <= DRAIN;
        end
        DRAIN: begin
          if (drain_done) begin
            host.host_out_valid <= 1'b0;
            host.host_in_ready  <= 1'b1;
            busy  <= 1'b0;
            row   <= 2'd0;
            col   <= 2'd0;
            state <= IDLE;
`ifdef TENSOR_HOST_SEQ_CHECKSUM_EN
          end else if (hs_out && last_elem) begin
            host.host_out_data <= csum;
            chk_phase <= 1'b1;
`endif
          end else if (hs_out) begin
            host.host_out_data <= result_q[nxt_row][nxt_col];
            row <= nxt_row;
            col <= nxt_col;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_core_host_sequencer.sv
// Directed bench for tensor_core_host_sequencer with a latency core model.
// Build with TENSOR_HOST_SEQ_CHECKSUM_EN to cover the checksum variant.
module tb_tensor_core_host_sequencer;

  logic clk;
  logic reset_in;

  logic signed [7:0] in1 [0:2][0:2];
  logic signed [7:0] in2 [0:2][0:2];
  logic signed [7:0] core_out [0:2][0:2];
  logic signed [7:0] core_a [0:2][0:2];
  logic signed [7:0] core_b [0:2][0:2];
  logic we;
  logic start;
  logic [1:0] op;
  logic busy;

  tensor_core_host_sequencer_if hif ();

  tensor_core_host_sequencer #(
    .COMPUTE_CYCLES(10),
    .DATA_W(8)
  ) dut (
    .tensor_core_clock(clk),
    .reset_in(reset_in),
    .host(hif),
    .tensor_core_input1(in1),
    .tensor_core_input2(in2),
    .tensor_core_register_file_write_enable(we),
    .should_start_tensor_core(start),
    .operation_select(op),
    .tensor_core_output(core_out),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [71:0] a;
    logic [71:0] b;
    logic [71:0] exp;
    logic [7:0]  csum;
  } vec_t;

  vec_t vt [0:6];

  int passed;
  int total;
  int we_cnt;
  int st_cnt;
  int we0;
  int st0;
  int in_bad;
  logic [1:0] last_op;
  int core_cnt;

  // core model: latches operands on write enable, result 9 edges after start
  function automatic logic [7:0] core_elem(input logic [1:0] o,
                                           input int i, input int j);
    int s;
    s = 0;
    if (o == 2'b00) begin
      for (int k = 0; k < 3; k++) begin
        s += int'(core_a[i][k]) * int'(core_b[k][j]);
      end
    end else if (o == 2'b01) begin
      s = int'(core_a[i][j]) + int'(core_b[i][j]);
    end else begin
      s = (core_a[i][j] < 0) ? 0 : int'(core_a[i][j]);
    end
    return s[7:0];
  endfunction

  always @(posedge clk) begin
    if (we) begin
      core_a <= in1;
      core_b <= in2;
    end
    if (start) begin
      core_cnt <= 9;
      core_out <= '{default: 8'sh55};
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end else if (core_cnt == 1) begin
      core_cnt <= 0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          core_out[i][j] <= core_elem(op, i, j);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_in) begin
      if (we) we_cnt <= we_cnt + 1;
      if (start) begin
        st_cnt  <= st_cnt + 1;
        last_op <= op;
      end
    end
  end

  function automatic logic [71:0] pk(input int e0, e1, e2, e3, e4,
                                     e5, e6, e7, e8);
    logic [7:0] b [0:8];
    b = '{8'(e0), 8'(e1), 8'(e2), 8'(e3), 8'(e4),
          8'(e5), 8'(e6), 8'(e7), 8'(e8)};
    return {b[8], b[7], b[6], b[5], b[4], b[3], b[2], b[1], b[0]};
  endfunction

  function automatic logic [71:0] all9(input int x);
    return pk(x, x, x, x, x, x, x, x, x);
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    hif.host_in_data  = d;
    hif.host_in_valid = 1'b1;
    while (!hif.host_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("in_timeout", n, 0);
    @(posedge clk);
    @(negedge clk);
    hif.host_in_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] d, input bit watch);
    int n;
    n = 0;
    hif.host_out_ready = 1'b1;
    while (!hif.host_out_valid && n < 100) begin
      if (watch && hif.host_in_ready) in_bad++;
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("out_timeout", n, 0);
    if (watch && hif.host_in_ready) in_bad++;
    d = hif.host_out_data;
    @(posedge clk);
    @(negedge clk);
    hif.host_out_ready = 1'b0;
  endtask

  task automatic load_job(input vec_t v, input bit gap, input bit cmd);
    we0 = we_cnt;
    st0 = st_cnt;
    if (cmd) send_byte(v.cmd);
    for (int i = 0; i < 18; i++) begin
      if (gap) begin
        hif.host_in_valid = 1'b0;
        @(negedge clk);
      end
      send_byte(i < 9 ? v.a[i*8 +: 8] : v.b[(i-9)*8 +: 8]);
    end
  endtask

  task automatic drain_job(input vec_t v, input int stall_at,
                           input bit watch);
    logic [7:0] d;
    logic [7:0] hold;
    bit ok;
    int n;
    for (int i = 0; i < 9; i++) begin
      if (i == stall_at) begin
        n = 0;
        while (!hif.host_out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        hold = hif.host_out_data;
        ok = hif.host_out_valid;
        repeat (5) begin
          @(negedge clk);
          if (!hif.host_out_valid || hif.host_out_data !== hold) ok = 0;
        end
        check("stall_hold", ok, 1);
      end
      recv_byte(d, watch);
      check($sformatf("res%0d", i), d, v.exp[i*8 +: 8]);
    end
`ifdef TENSOR_HOST_SEQ_CHECKSUM_EN
    recv_byte(d, watch);
    check("csum", d, v.csum);
`endif
    check("busy_end", busy, 0);
    check("ovalid_end", hif.host_out_valid, 0);
    check("we_pulses", we_cnt - we0, 1);
    check("start_pulses", st_cnt - st0, 1);
    check("op_at_start", last_op, v.cmd[1:0]);
  endtask

  initial begin
    int st_save;
    passed = 0;
    total  = 0;
    we_cnt = 0;
    st_cnt = 0;
    in_bad = 0;
    core_cnt = 0;
    last_op  = 2'b00;
    hif.host_in_data   = 8'h00;
    hif.host_in_valid  = 1'b0;
    hif.host_out_ready = 1'b0;
    reset_in = 1'b1;

    vt[0] = '{8'h00, pk(1,0,0,0,1,0,0,0,1), pk(1,2,3,4,5,6,7,8,9),
              pk(1,2,3,4,5,6,7,8,9), 8'h01};
    vt[1] = '{8'h01, all9(5), all9(-3), all9(2), 8'h02};
    vt[2] = '{8'h02, pk(-1,2,-3,4,-5,6,-7,8,-9), all9(0),
              pk(0,2,0,4,0,6,0,8,0), 8'h08};
    vt[3] = '{8'h00, all9(10), all9(10), all9(44), 8'h2C};
    vt[4] = '{8'h03, pk(127,-128,0,1,-1,50,-50,100,-100), all9(1),
              pk(127,0,0,1,0,50,0,100,0), 8'h28};
    vt[5] = '{8'h01, all9(100), all9(100), all9(200), 8'hC8};
    vt[6] = '{8'h00, pk(1,2,3,4,5,6,7,8,9), pk(9,8,7,6,5,4,3,2,1),
              pk(30,24,18,84,69,54,138,114,90), 8'h91};

    repeat (3) @(negedge clk);
    check("rst_in_ready", hif.host_in_ready, 1);
    check("rst_out_valid", hif.host_out_valid, 0);
    check("rst_out_data", hif.host_out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ctl", {we, start, op}, 0);
    check("rst_in1", in1[1][1], 0);
    reset_in = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      load_job(vt[v], 1'b0, 1'b1);
      check("busy_loaded", busy, 1);
      drain_job(vt[v], -1, 1'b0);
    end

    // backpressure in both directions
    load_job(vt[6], 1'b1, 1'b1);
    drain_job(vt[6], 4, 1'b0);

    // reset partway through LOAD
    send_byte(8'h01);
    for (int i = 0; i < 8; i++) send_byte(vt[1].a[i*8 +: 8]);
    st_save = st_cnt;
    reset_in = 1'b1;
    @(negedge clk);
    reset_in = 1'b0;
    repeat (25) @(negedge clk);
    check("abort_no_start", st_cnt, st_save);
    check("abort_busy", busy, 0);
    load_job(vt[1], 1'b0, 1'b1);
    drain_job(vt[1], -1, 1'b0);

    // asynchronous reset during WAIT
    load_job(vt[2], 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("wait_busy", busy, 1);
    #2 reset_in = 1'b1;
    #1;
    check("async_in1", in1[0][0], 0);
    check("async_in2", in2[2][2], 0);
    check("async_ctl", {busy, we, start, op}, 0);
    check("async_ready", hif.host_in_ready, 1);
    check("async_ovalid", hif.host_out_valid, 0);
    @(negedge clk);
    reset_in = 1'b0;
    @(negedge clk);

    // next command waits behind an active drain
    load_job(vt[0], 1'b0, 1'b1);
    hif.host_in_data  = vt[1].cmd;
    hif.host_in_valid = 1'b1;
    in_bad = 0;
    drain_job(vt[0], -1, 1'b1);
    check("b2b_ready_low", in_bad, 0);
    check("b2b_ready_back", hif.host_in_ready, 1);
    load_job(vt[1], 1'b0, 1'b1);
    drain_job(vt[1], -1, 1'b0);

`ifdef TENSOR_HOST_SEQ_CHECKSUM_EN
    send_byte(8'h05);
    check("reject_busy", busy, 0);
    check("reject_ready", hif.host_in_ready, 1);
    load_job(vt[5], 1'b0, 1'b1);
    drain_job(vt[5], -1, 1'b0);
`else
    begin
      vec_t hv;
      hv = vt[5];
      hv.cmd = 8'hFD;
      load_job(hv, 1'b0, 1'b1);
      drain_job(hv, -1, 1'b0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

// File: doc/tensor_core_host_sequencer.md
Name: tensor_core_host_sequencer

Overview:
- Host-side driver for the 3x3 small tensor core.
- Accepts a byte-serial command stream over a valid/ready port and assembles the two 3x3 signed 8-bit operand matrices.
- Sequences the core's write-enable, start and op-select controls, waits for completion, captures the 3x3 result and streams it back byte-serially over a second valid/ready port.
- Sits between the external host link and the tensor core, one per core.

Parameters:
- COMPUTE_CYCLES, 10, clock cycles spent in WAIT after start before the result is captured; must cover the core's full 9-element sweep.
- DATA_W, 8, width of host bytes and matrix elements.

Ports:
- tensor_core_clock  input  1  single clock; all state on rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- host_in_data  input  8  command/operand byte.
- host_in_valid  input  1  host_in_data is valid.
- host_in_ready  output  1  sequencer accepts a byte this cycle.
- host_out_data  output  8  result byte.
- host_out_valid  output  1  host_out_data is valid.
- host_out_ready  input  1  host accepts the result byte.
- tensor_core_input1  output  signed 8 x [3][3]  operand A to core.
- tensor_core_input2  output  signed 8 x [3][3]  operand B to core.
- tensor_core_register_file_write_enable  output  1  one-cycle pulse after load.
- should_start_tensor_core  output  1  one-cycle start pulse.
- operation_select  output  2  00 matmul, 01 add, 1x relu.
- tensor_core_output  input  signed 8 x [3][3]  result from core.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately) sets:
  - state to IDLE;
  - all matrix outputs, result buffer, host_out_data and byte counter to 0;
  - host_out_valid, write_enable, start and busy to 0;
  - operation_select to 00;
  - host_in_ready to 1.
- Reset mid-operation discards any partial load or undrained result. No output pulse is generated during or on exit from reset.
- Transfer rule: a byte moves only on a rising edge with valid && ready.
- IDLE:
  - host_in_ready=1.
  - The accepted byte is the command; bits[1:0] are latched into operation_select and bits[7:2] are ignored.
  - Go to LOAD with byte counter = 0.
- LOAD:
  - host_in_ready=1.
  - 18 bytes, row-major: counter 0..8 writes tensor_core_input1[c/3][c%3], counter 9..17 writes tensor_core_input2[(c-9)/3][(c-9)%3].
  - Host stalls (valid low) are tolerated indefinitely.
  - After byte 17, go to WRITE.
- WRITE:
  - host_in_ready=0; tensor_core_register_file_write_enable=1 for exactly this cycle.
  - Go to START.
- START:
  - should_start_tensor_core=1 for exactly this cycle.
  - Load the wait counter with COMPUTE_CYCLES-1; go to WAIT.
- WAIT:
  - Decrement each cycle; operands and operation_select are held stable.
  - At 0, go to CAPTURE.
- CAPTURE:
  - Latch all nine tensor_core_output elements into the result buffer.
  - Byte counter = 0; go to DRAIN.
- DRAIN:
  - host_out_valid=1; host_out_data = result[c/3][c%3], row-major.
  - Data is held stable while host_out_ready=0.
  - Advance on each handshake; after element 8 (or the checksum byte, when enabled) go to IDLE.
  - host_out_valid drops in the cycle IDLE is entered.
- host_in_ready is 0 in WRITE, START, WAIT, CAPTURE and DRAIN. Bytes offered then are not consumed, and no input/output overlap is allowed.
- Operand registers keep their last values after returning to IDLE. They are overwritten only by the next LOAD.
- Relu and add commands still require all 18 operand bytes; operand B is ignored by the core for relu.
- Elements are signed two's complement. The sequencer performs no arithmetic and passes results through unmodified, including the core's 8-bit truncation.
- Throughput: a minimum of 1 + 18 + 1 + 1 + COMPUTE_CYCLES + 1 + 9 cycles per job with no stalls.

Optional Feature:
- Macro: TENSOR_HOST_SEQ_CHECKSUM_EN.
- When defined:
  - DRAIN emits a 10th byte equal to the XOR of the nine result bytes before returning to IDLE.
  - A command with bits[7:2] != 0 is rejected: the sequencer stays in IDLE, and the byte is consumed and dropped.
- When undefined:
  - Exactly 9 result bytes are emitted.
  - Command bits[7:2] are ignored.

Test Plan:
- Matmul, identity times M: send 0x00; A=I (1,0,0,0,1,0,0,0,1); B=1..9 -> write_enable pulse, then one start pulse with operation_select=00; output bytes 1..9; busy falls after last handshake.
- Add: send 0x01; A=all 5, B=all -3 -> nine bytes of 2. Checksum build: 10th byte = 0x02.
- Relu: send 0x02; A = -1,2,-3,4,-5,6,-7,8,-9; B=0 -> 0,2,0,4,0,6,0,8,0.
- Backpressure: valid toggles every other cycle in LOAD and host_out_ready=0 for 5 cycles mid-DRAIN -> identical results; host_out_data stable while stalled; no byte lost or duplicated.
- Reset mid-operation: assert reset_in after byte 7 of LOAD, then run a full add job -> no start pulse from the aborted job; the new job's result is correct. Also assert reset_in asynchronously during WAIT -> all outputs 0 immediately.
- Back-to-back jobs: second command is presented while DRAIN is active -> host_in_ready=0 until IDLE, then the second job completes correctly.
